dot_accumulator: RTL and testbench
==================================

DOT_ACCUMULATOR -- requirements
Module: dot_accumulator

Interface
REQ-001 SHALL have parameter LEN_W, default 8, giving the width of the term-count input.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-005 SHALL have port Len  input  LEN_W  number of terms to sum; sampled when Start is accepted.
REQ-006 SHALL have port In_Valid  input  1  upstream partial product-sum C is present.
REQ-007 SHALL have port In_Data  input  32  upstream partial sum (unsigned).
REQ-008 SHALL have port In_Ready  output  1  block accepts In_Data this cycle.
REQ-009 SHALL have port Out_Valid  output  1  Out_Data holds a finished sum.
REQ-010 SHALL have port Out_Ready  input  1  downstream takes the result.
REQ-011 SHALL have port Out_Data  output  32  accumulated sum, modulo 2^32.
REQ-012 SHALL have port Ovf  output  1  sticky unsigned carry-out flag for the current sum.
REQ-013 SHALL have port Busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, DONE; all outputs registered or decoded from state only.
REQ-015 In IDLE with Start=1 and Len!=0 SHALL clear accumulator, count and Ovf, latch Len, and move to ACC.
REQ-016 In IDLE with Start=1 and Len=0 SHALL clear accumulator and Ovf and move directly to DONE (result 0).
REQ-017 In IDLE with Start=0 SHALL hold all state; Out_Data retains the last result.
REQ-018 In_Ready SHALL be 1 exactly when state is ACC.
REQ-019 A beat SHALL be accepted on an edge where In_Valid=1 and In_Ready=1; only accepted beats change the accumulator.
REQ-020 Each accepted beat SHALL set acc <= acc + In_Data (32-bit wrap) and increment count.
REQ-021 Ovf SHALL be set on any accepted beat whose 33-bit sum carries out; it remains set until the next Start or Reset.
REQ-022 On accepting beat number Len (count = Len-1 before the edge), the FSM SHALL move to DONE; Out_Valid is high in the following cycle (one-cycle latency from last beat).
REQ-023 In DONE Out_Valid SHALL be 1 and Out_Data/Ovf SHALL be stable until the handshake completes.
REQ-024 In DONE with Out_Ready=1 the FSM SHALL return to IDLE on that edge; Out_Valid drops next cycle.
REQ-025 Start SHALL be ignored in ACC and DONE; Len changes outside the Start-accept edge SHALL have no effect.
REQ-026 In_Valid gaps (bubbles) during ACC SHALL stall counting without error; no timeout.
REQ-027 Len = 2^LEN_W-1 SHALL be supported; count SHALL NOT wrap before termination.
REQ-028 Out_Data SHALL equal the accumulator register at all times.

Reset
REQ-029 Reset=1 on a rising edge SHALL force IDLE, accumulator=0, count=0, Ovf=0, regardless of state, including mid-ACC and DONE.
REQ-030 After reset, outputs SHALL be In_Ready=0, Out_Valid=0, Out_Data=0, Ovf=0, Busy=0.
REQ-031 Reset SHALL take priority over Start, In_Valid and Out_Ready in the same cycle.

Verification
REQ-032 Start, Len=3; beats 10, 20, 30 back-to-back -> Out_Valid one cycle after third beat, Out_Data=60, Ovf=0.
REQ-033 Start, Len=4; beats 5,_,7,_,9,1 with bubbles -> Out_Data=22 after fourth accepted beat only.
REQ-034 Start, Len=2; beats 0xFFFFFFF0, 0x20 -> Out_Data=0x10, Ovf=1; next Start clears Ovf=0.
REQ-035 Start, Len=0 -> DONE next cycle, Out_Data=0, no In_Ready asserted.
REQ-036 Result held with Out_Ready=0 for 5 cycles while Start pulses -> Out_Data/Out_Valid unchanged, no new run; Out_Ready=1 -> IDLE.
REQ-037 Reset asserted after 2 of 4 beats -> next cycle IDLE, Out_Data=0, In_Ready=0; fresh run gives correct sum.

Source files
------------

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums a run of Len unsigned 32-bit partial sums arriving on a
// valid/ready stream and presents the 32-bit wrapped total together with a
// sticky carry-out flag on a valid/ready result port.
module dot_accumulator #(
    parameter int LEN_W = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [LEN_W-1:0] Len,
    input  logic             In_Valid,
    input  logic [31:0]      In_Data,
    output logic             In_Ready,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [31:0]      Out_Data,
    output logic             Ovf,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             ovf;
    logic [32:0]      sum;
    logic             beat;
    logic             last_beat;

    // A beat is taken only while in ACC; the wide sum exposes the carry-out.
    always_comb begin
        sum       = {1'b0, acc} + {1'b0, In_Data};
        beat      = (state == ACC) && In_Valid;
        last_beat = beat && (cnt == (len_q - LEN_W'(1)));
    end

    // State register; Reset wins over every other input.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: Start only matters in IDLE, a zero-length run skips ACC.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_next = (Len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (Out_Ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: clear on an accepted Start, accumulate on accepted beats, hold otherwise.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
        end else if (state == IDLE && Start) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            len_q <= Len;
        end else if (beat) begin
            acc <= sum[31:0];
            cnt <= cnt + LEN_W'(1);
            if (sum[32]) begin
                ovf <= 1'b1;
            end
        end
    end

    // Outputs are either registers or pure state decodes.
    always_comb begin
        In_Ready  = (state == ACC);
        Out_Valid = (state == DONE);
        Busy      = (state != IDLE);
        Out_Data  = acc;
        Ovf       = ovf;
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// tb_dot_accumulator: directed self-checking bench for dot_accumulator.
module tb_dot_accumulator;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [7:0]  Len;
    logic        In_Valid;
    logic [31:0] In_Data;
    logic        In_Ready;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Data;
    logic        Ovf;
    logic        Busy;

    int checks;
    int errors;

    dot_accumulator #(.LEN_W(8)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Len       (Len),
        .In_Valid  (In_Valid),
        .In_Data   (In_Data),
        .In_Ready  (In_Ready),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Data  (Out_Data),
        .Ovf       (Ovf),
        .Busy      (Busy)
    );

    // 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Drive inputs, let one rising edge pass, then settle 1 ns past it.
    task automatic applyStimulus(input logic start, input logic [7:0] len,
                                 input logic valid, input logic [31:0] data,
                                 input logic ready);
        Start     = start;
        Len       = len;
        In_Valid  = valid;
        In_Data   = data;
        Out_Ready = ready;
        @(posedge Clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Reset     = 1'b1;
        Start     = 1'b0;
        Len       = 8'd0;
        In_Valid  = 1'b0;
        In_Data   = 32'd0;
        Out_Ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Reset state
        checkOutput("rst_in_ready", {31'd0, In_Ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("rst_out_data", Out_Data, 32'd0);
        checkOutput("rst_ovf", {31'd0, Ovf}, 32'd0);
        checkOutput("rst_busy", {31'd0, Busy}, 32'd0);

        // Len=3, back-to-back 10,20,30 -> 60
        applyStimulus(1'b1, 8'd3, 1'b0, 32'd0, 1'b0);
        checkOutput("r1_in_ready", {31'd0, In_Ready}, 32'd1);
        checkOutput("r1_busy", {31'd0, Busy}, 32'd1);
        applyStimulus(1'b0, 8'd3, 1'b1, 32'd10, 1'b0);
        applyStimulus(1'b0, 8'd3, 1'b1, 32'd20, 1'b0);
        checkOutput("r1_mid_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("r1_mid_data", Out_Data, 32'd30);
        applyStimulus(1'b0, 8'd3, 1'b1, 32'd30, 1'b0);
        checkOutput("r1_out_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("r1_out_data", Out_Data, 32'd60);
        checkOutput("r1_ovf", {31'd0, Ovf}, 32'd0);
        checkOutput("r1_in_ready_done", {31'd0, In_Ready}, 32'd0);
        applyStimulus(1'b0, 8'd3, 1'b0, 32'd0, 1'b1);
        checkOutput("r1_idle_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("r1_idle_busy", {31'd0, Busy}, 32'd0);
        checkOutput("r1_idle_hold", Out_Data, 32'd60);

        // Len=4 with bubbles: 5,_,7,_,9,1 -> 22
        applyStimulus(1'b1, 8'd4, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd5, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b0, 32'd100, 1'b0);
        checkOutput("r2_bubble_data", Out_Data, 32'd5);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd7, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b0, 32'd100, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd9, 1'b0);
        checkOutput("r2_three_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("r2_three_data", Out_Data, 32'd21);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd1, 1'b0);
        checkOutput("r2_out_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("r2_out_data", Out_Data, 32'd22);
        applyStimulus(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);

        // Len=2 overflow: FFFFFFF0 + 20 -> 10, Ovf sticky until next Start
        applyStimulus(1'b1, 8'd2, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 8'd2, 1'b1, 32'hFFFF_FFF0, 1'b0);
        checkOutput("r3_no_ovf_yet", {31'd0, Ovf}, 32'd0);
        applyStimulus(1'b0, 8'd2, 1'b1, 32'h0000_0020, 1'b0);
        checkOutput("r3_out_data", Out_Data, 32'h10);
        checkOutput("r3_ovf", {31'd0, Ovf}, 32'd1);
        applyStimulus(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("r3_idle_ovf", {31'd0, Ovf}, 32'd1);
        applyStimulus(1'b1, 8'd1, 1'b0, 32'd0, 1'b0);
        checkOutput("r4_ovf_cleared", {31'd0, Ovf}, 32'd0);
        checkOutput("r4_acc_cleared", Out_Data, 32'd0);
        applyStimulus(1'b0, 8'd1, 1'b1, 32'd5, 1'b0);
        checkOutput("r4_out_data", Out_Data, 32'd5);

        // Result held with Out_Ready=0 while Start pulses
        for (int i = 0; i < 5; i++) begin
            applyStimulus((i % 2) == 0, 8'd0, 1'b1, 32'd77, 1'b0);
            checkOutput("hold_valid", {31'd0, Out_Valid}, 32'd1);
            checkOutput("hold_data", Out_Data, 32'd5);
        end
        applyStimulus(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("hold_release_busy", {31'd0, Busy}, 32'd0);
        checkOutput("hold_release_data", Out_Data, 32'd5);

        // Len=0 -> DONE next cycle with result 0, no In_Ready
        applyStimulus(1'b1, 8'd0, 1'b0, 32'd0, 1'b0);
        checkOutput("len0_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("len0_in_ready", {31'd0, In_Ready}, 32'd0);
        checkOutput("len0_data", Out_Data, 32'd0);
        applyStimulus(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);

        // Reset after 2 of 4 beats, with competing inputs active
        applyStimulus(1'b1, 8'd4, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd1, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd2, 1'b0);
        checkOutput("rstmid_pre_data", Out_Data, 32'd3);
        Reset = 1'b1;
        applyStimulus(1'b1, 8'd4, 1'b1, 32'd3, 1'b1);
        Reset = 1'b0;
        checkOutput("rstmid_busy", {31'd0, Busy}, 32'd0);
        checkOutput("rstmid_data", Out_Data, 32'd0);
        checkOutput("rstmid_in_ready", {31'd0, In_Ready}, 32'd0);
        checkOutput("rstmid_out_valid", {31'd0, Out_Valid}, 32'd0);
        applyStimulus(1'b1, 8'd4, 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd100, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd200, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd300, 1'b0);
        applyStimulus(1'b0, 8'd4, 1'b1, 32'd400, 1'b0);
        checkOutput("fresh_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("fresh_data", Out_Data, 32'd1000);
        applyStimulus(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);

        // Maximum length 255, with Start/Len churn mid-run that must be ignored
        applyStimulus(1'b1, 8'd255, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 254; i++) begin
            applyStimulus(i == 10, (i == 10) ? 8'd2 : 8'd255, 1'b1, 32'd1, 1'b0);
        end
        checkOutput("max_254_valid", {31'd0, Out_Valid}, 32'd0);
        checkOutput("max_254_data", Out_Data, 32'd254);
        applyStimulus(1'b0, 8'd0, 1'b1, 32'd1, 1'b0);
        checkOutput("max_valid", {31'd0, Out_Valid}, 32'd1);
        checkOutput("max_data", Out_Data, 32'd255);
        applyStimulus(1'b0, 8'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("max_idle_busy", {31'd0, Busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
